// File: rtl/boot_loader.sv
// boot_loader: brings up the Astrio core. The CPU is held in reset while a
// program image arrives as a byte stream: a 16-bit big-endian word count N,
// then N big-endian 32-bit instruction words. Each completed word is written
// to the Fetcher through its load port, and then the CPU is released.
//
// Optional feature: define BOOT_LOADER_TIMEOUT_EN to abort a load into ERROR
// when no byte arrives for TIMEOUT_CYCLES cycles while bytes are expected.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   start              single-cycle pulse that begins a load (ignored while busy)
//   byte_valid/_data   byte source; byte_ready accepts it (registered)
//   fetcher_loading    one-cycle Fetcher write strobe
//   fetcher_load_inst  assembled instruction word (held outside WRITE)
//   chip_select        Fetcher enable
//   cpu_rst            reset to the Astrio core, active-high
//   word_count         words written in the current load
//   busy, done, error  load status
module boot_loader #(
    parameter int MAX_WORDS      = 256,
    parameter int RELEASE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        fetcher_loading,
    output logic [31:0] fetcher_load_inst,
    output logic        chip_select,
    output logic        cpu_rst,
    output logic [15:0] word_count,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_HI  = 3'd1,
        S_LEN_LO  = 3'd2,
        S_DATA    = 3'd3,
        S_WRITE   = 3'd4,
        S_RELEASE = 3'd5,
        S_RUN     = 3'd6,
        S_ERROR   = 3'd7
    } state_t;

    localparam logic [16:0] MAX_LEN     = 17'(MAX_WORDS);
    localparam logic [31:0] REL_PRELOAD = 32'(RELEASE_CYCLES - 1);

    state_t        state_r;
    state_t        state_s;
    logic          xfer_s;
    logic          timeout_s;
    logic [15:0]   len_s;
    logic [7:0]    len_hi_r;
    logic [15:0]   len_r;
    logic [1:0]    byte_idx_r;
    logic [23:0]   partial_r;
    logic [31:0]   rel_cnt_r;

    // byte_ready is a register, so the handshake has no valid->ready path.
    assign xfer_s = byte_valid && byte_ready;
    assign len_s  = {len_hi_r, byte_data};

    // True in the states that wait for incoming bytes.
    function automatic logic is_receiving(input state_t s);
        return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA);
    endfunction

`ifdef BOOT_LOADER_TIMEOUT_EN
    logic [31:0] idle_cnt_r;

    assign timeout_s = is_receiving(state_r) && !xfer_s &&
                       (idle_cnt_r >= 32'(TIMEOUT_CYCLES - 1));

    // Idle-cycle counter; held at zero outside the receiving states so that
    // entry to LEN_HI always starts a fresh count.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_r <= 32'd0;
        end else if (!is_receiving(state_r) || xfer_s) begin
            idle_cnt_r <= 32'd0;
        end else begin
            idle_cnt_r <= idle_cnt_r + 32'd1;
        end
    end
`else
    logic unused_timeout_s;

    assign timeout_s        = 1'b0;
    // The timeout parameter only matters when the feature is built.
    assign unused_timeout_s = (TIMEOUT_CYCLES != 0);
`endif

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_s = S_LEN_HI;
                else       state_s = S_IDLE;
            end
            S_LEN_HI: begin
                if (timeout_s)   state_s = S_ERROR;
                else if (xfer_s) state_s = S_LEN_LO;
                else             state_s = S_LEN_HI;
            end
            S_LEN_LO: begin
                if (timeout_s) begin
                    state_s = S_ERROR;
                end else if (xfer_s) begin
                    if ((len_s == 16'd0) || ({1'b0, len_s} > MAX_LEN)) state_s = S_ERROR;
                    else                                              state_s = S_DATA;
                end else begin
                    state_s = S_LEN_LO;
                end
            end
            S_DATA: begin
                if (timeout_s)                          state_s = S_ERROR;
                else if (xfer_s && byte_idx_r == 2'd3)  state_s = S_WRITE;
                else                                    state_s = S_DATA;
            end
            S_WRITE: begin
                if (word_count + 16'd1 == len_r) state_s = S_RELEASE;
                else                             state_s = S_DATA;
            end
            S_RELEASE: begin
                if (rel_cnt_r == 32'd0) state_s = S_RUN;
                else                    state_s = S_RELEASE;
            end
            S_RUN: begin
                if (start) state_s = S_LEN_HI;
                else       state_s = S_RUN;
            end
            S_ERROR: begin
                if (start) state_s = S_LEN_HI;
                else       state_s = S_ERROR;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State, datapath and outputs; outputs are registered from the next state
    // so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r           <= S_IDLE;
            byte_ready        <= 1'b0;
            fetcher_loading   <= 1'b0;
            fetcher_load_inst <= 32'd0;
            chip_select       <= 1'b0;
            cpu_rst           <= 1'b1;
            word_count        <= 16'd0;
            busy              <= 1'b0;
            done              <= 1'b0;
            error             <= 1'b0;
            len_hi_r          <= 8'd0;
            len_r             <= 16'd0;
            byte_idx_r        <= 2'd0;
            partial_r         <= 24'd0;
            rel_cnt_r         <= 32'd0;
        end else begin
            state_r         <= state_s;
            byte_ready      <= is_receiving(state_s);
            fetcher_loading <= (state_s == S_WRITE);
            chip_select     <= (state_s != S_IDLE) && (state_s != S_ERROR);
            cpu_rst         <= (state_s != S_RUN);
            busy            <= is_receiving(state_s) || (state_s == S_WRITE) ||
                               (state_s == S_RELEASE);
            done            <= (state_s == S_RUN);
            error           <= (state_s == S_ERROR);

            // A new load restarts the Fetcher address and the byte index.
            if ((state_s == S_LEN_HI) && (state_r != S_LEN_HI)) begin
                word_count <= 16'd0;
                byte_idx_r <= 2'd0;
            end else if (state_r == S_WRITE) begin
                word_count <= word_count + 16'd1;
            end

            if (xfer_s) begin
                case (state_r)
                    S_LEN_HI: len_hi_r <= byte_data;
                    S_LEN_LO: begin
                        len_r      <= len_s;
                        byte_idx_r <= 2'd0;
                    end
                    S_DATA: begin
                        byte_idx_r <= byte_idx_r + 2'd1;
                        partial_r  <= {partial_r[15:0], byte_data};
                        // First byte received lands in bits [31:24].
                        if (byte_idx_r == 2'd3) begin
                            fetcher_load_inst <= {partial_r, byte_data};
                        end
                    end
                    default: len_hi_r <= len_hi_r;
                endcase
            end

            // RELEASE lasts RELEASE_CYCLES cycles: preload N-1, leave at zero.
            if (state_r == S_WRITE) begin
                rel_cnt_r <= REL_PRELOAD;
            end else if ((state_r == S_RELEASE) && (rel_cnt_r != 32'd0)) begin
                rel_cnt_r <= rel_cnt_r - 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
module tb_boot_loader;

    localparam int MAXW = 8;
    localparam int REL  = 4;
    localparam int TOUT = 16;

    logic        clk;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        fetcher_loading;
    logic [31:0] fetcher_load_inst;
    logic        chip_select;
    logic        cpu_rst;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
    logic        error;

    boot_loader #(
        .MAX_WORDS      (MAXW),
        .RELEASE_CYCLES (REL),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .byte_valid        (byte_valid),
        .byte_data         (byte_data),
        .byte_ready        (byte_ready),
        .fetcher_loading   (fetcher_loading),
        .fetcher_load_inst (fetcher_load_inst),
        .chip_select       (chip_select),
        .cpu_rst           (cpu_rst),
        .word_count        (word_count),
        .busy              (busy),
        .done              (done),
        .error             (error)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_acc = 0;
    logic prev_cpu_rst = 1'b1;
    logic [31:0] strobe_q[$];
    int          strobe_cyc_q[$];
    int          fall_q[$];
    logic [31:0] img[0:15];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Fetcher-side observer: records every write strobe and cpu_rst release.
    always @(negedge clk) begin
        if (fetcher_loading === 1'b1) begin
            strobe_q.push_back(fetcher_load_inst);
            strobe_cyc_q.push_back(cyc);
        end
        if (prev_cpu_rst === 1'b1 && cpu_rst === 1'b0) fall_q.push_back(cyc);
        prev_cpu_rst <= cpu_rst;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_obs();
        strobe_q.delete();
        strobe_cyc_q.delete();
        fall_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers one byte after 'gap' idle cycles and holds it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (byte_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (byte_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL byte_accept: byte %h not accepted within %0d cycles", b, n);
        end
        last_acc = cyc;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // Streams a length header and nw words of img[] big-endian.
    task automatic send_image(input logic [15:0] n, input int nw, input int gmax);
        logic [31:0] w;
        send_byte(n[15:8], $urandom_range(0, gmax));
        send_byte(n[7:0], $urandom_range(0, gmax));
        for (int i = 0; i < nw; i++) begin
            w = img[i];
            for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], $urandom_range(0, gmax));
        end
    endtask

    task automatic wait_settle();
        int n;
        n = 0;
        while (done !== 1'b1 && error !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if ({byte_ready, fetcher_loading, chip_select, busy, done, error, word_count,
             fetcher_load_inst, cpu_rst} !== {6'd0, 16'd0, 32'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b ld=%b cs=%b busy=%b done=%b err=%b wc=%h inst=%h cpu_rst=%b, want all 0 and cpu_rst=1",
                     byte_ready, fetcher_loading, chip_select, busy, done, error,
                     word_count, fetcher_load_inst, cpu_rst);
        end
    endtask

    task automatic test_back_to_back();
        int acc1;
        clear_obs();
        pulse_start();
        n_cmp++;
        if (byte_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_ready: got byte_ready=%b want 1", byte_ready);
        end
        img[0] = 32'h20080005;
        img[1] = 32'h00000008;
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        for (int k = 0; k < 4; k++) send_byte(img[0][31-8*k -: 8], 0);
        acc1 = last_acc;
        send_byte(img[1][31:24], 0);
        n_cmp++;
        if (last_acc !== acc1 + 2) begin
            n_fail++;
            $display("FAIL ready_after_write: next byte at %0d want %0d", last_acc, acc1 + 2);
        end
        for (int k = 1; k < 4; k++) send_byte(img[1][31-8*k -: 8], 0);
        wait_settle();
        @(negedge clk);
        n_cmp++;
        if (strobe_q.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_strobes: got %0d want 2", strobe_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (strobe_q[i] !== img[i]) begin
                    n_fail++;
                    $display("FAIL b2b_word%0d: got %h want %h", i, strobe_q[i], img[i]);
                end
            end
            n_cmp++;
            if (strobe_cyc_q[0] !== acc1 + 1 || strobe_cyc_q[1] !== last_acc + 1) begin
                n_fail++;
                $display("FAIL b2b_strobe_time: got %0d,%0d want %0d,%0d",
                         strobe_cyc_q[0], strobe_cyc_q[1], acc1 + 1, last_acc + 1);
            end
            n_cmp++;
            if (fall_q.size() != 1 || fall_q[0] !== strobe_cyc_q[1] + REL + 1) begin
                n_fail++;
                $display("FAIL b2b_release_time: got %0d falls (first %0d) want 1 at %0d",
                         fall_q.size(), (fall_q.size() > 0) ? fall_q[0] : -1,
                         strobe_cyc_q[1] + REL + 1);
            end
        end
        n_cmp++;
        if ({word_count, done, cpu_rst, chip_select, busy} !== {16'd2, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_final: got wc=%0d done=%b cpu_rst=%b cs=%b busy=%b want 2 1 0 1 0",
                     word_count, done, cpu_rst, chip_select, busy);
        end
    endtask

    // Random lengths (including 0 and > MAX_WORDS) against a simple model:
    // valid length -> every word appears once, in order, then done.
    task automatic test_random_loads();
        int  n;
        logic bad;
        for (int it = 0; it < 10; it++) begin
            n = (it == 0) ? 0 : (it == 1) ? MAXW + 1 : (it == 2) ? MAXW : $urandom_range(0, MAXW + 2);
            bad = (n == 0) || (n > MAXW);
            for (int i = 0; i < 16; i++) img[i] = $urandom();
            clear_obs();
            pulse_start();
            send_image(16'(n), bad ? 0 : n, 2);
            wait_settle();
            repeat (2) @(negedge clk);
            n_cmp++;
            if (error !== bad || done !== !bad || cpu_rst !== bad || chip_select !== !bad) begin
                n_fail++;
                $display("FAIL rand_status it%0d N=%0d: got err=%b done=%b cpu_rst=%b cs=%b",
                         it, n, error, done, cpu_rst, chip_select);
            end
            n_cmp++;
            if (strobe_q.size() != (bad ? 0 : n)) begin
                n_fail++;
                $display("FAIL rand_count it%0d: got %0d strobes want %0d", it, strobe_q.size(), bad ? 0 : n);
            end else begin
                for (int i = 0; i < strobe_q.size(); i++) begin
                    n_cmp++;
                    if (strobe_q[i] !== img[i]) begin
                        n_fail++;
                        $display("FAIL rand_word it%0d[%0d]: got %h want %h", it, i, strobe_q[i], img[i]);
                    end
                end
            end
            if (!bad) begin
                n_cmp++;
                if (word_count !== 16'(n)) begin
                    n_fail++;
                    $display("FAIL rand_wc it%0d: got %0d want %0d", it, word_count, n);
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        clear_obs();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cpu_rst !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_idle: got cpu_rst=%b busy=%b rdy=%b want 1 0 0", cpu_rst, busy, byte_ready);
        end
        img[0] = 32'h13572468;
        pulse_start();
        send_image(16'd1, 1, 1);
        wait_settle();
        @(negedge clk);
        n_cmp++;
        if (strobe_q.size() != 1 || strobe_q[0] !== img[0] || word_count !== 16'd1) begin
            n_fail++;
            $display("FAIL rst_mid_reload: got %0d strobes first %h wc=%0d want 1 %h 1",
                     strobe_q.size(), (strobe_q.size() > 0) ? strobe_q[0] : 32'd0, word_count, img[0]);
        end
    endtask

    task automatic test_restart_run();
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (byte_ready !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL run_no_accept: got rdy=%b done=%b want 0 1", byte_ready, done);
        end
        byte_valid = 1'b0;
        clear_obs();
        pulse_start();
        n_cmp++;
        if (cpu_rst !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_rst: got cpu_rst=%b done=%b want 1 0", cpu_rst, done);
        end
        img[0] = $urandom();
        send_image(16'd1, 1, 0);
        wait_settle();
        @(negedge clk);
        n_cmp++;
        if (word_count !== 16'd1 || strobe_q.size() != 1 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_reload: got wc=%0d strobes=%0d done=%b want 1 1 1",
                     word_count, strobe_q.size(), done);
        end else begin
            n_cmp++;
            if (strobe_q[0] !== img[0]) begin
                n_fail++;
                $display("FAIL restart_word: got %h want %h", strobe_q[0], img[0]);
            end
        end
    endtask

    task automatic test_timeout();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hC3, 0);
`ifdef BOOT_LOADER_TIMEOUT_EN
        repeat (TOUT + 4) @(negedge clk);
        n_cmp++;
        if (error !== 1'b1 || busy !== 1'b0 || cpu_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_error: got err=%b busy=%b cpu_rst=%b want 1 0 1", error, busy, cpu_rst);
        end
`else
        repeat (1000) @(negedge clk);
        n_cmp++;
        if (error !== 1'b0 || busy !== 1'b1 || byte_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL no_timeout_wait: got err=%b busy=%b rdy=%b want 0 1 1", error, busy, byte_ready);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_random_loads();
        test_rst_mid();
        test_restart_run();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
